uart_rx_ex: RTL
===============

UART_RX_EX -- requirements
Module: uart_rx_ex

Interface
REQ-001 SHALL have parameter CLOCK, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line rate in bit/s; BIT_CYC = CLOCK/BAUD (integer division), MID = BIT_CYC/2.
REQ-003 SHALL have parameter DATA_BITS, default 8, payload width, legal range 5..9.
REQ-004 SHALL have parameter PARITY, default "NONE", one of "NONE", "ODD", "EVEN".
REQ-005 SHALL have parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port rx_data  output  DATA_BITS  received payload, LSB first on the line.
REQ-010 SHALL have port rx_vld  output  1  rx_data and error flags valid; held until accepted.
REQ-011 SHALL have port rx_rdy  input  1  consumer accepts word when rx_vld && rx_rdy.
REQ-012 SHALL have port parity_err  output  1  parity mismatch for the word held; valid with rx_vld.
REQ-013 SHALL have port frame_err  output  1  any stop bit sampled 0 for the word held; valid with rx_vld.
REQ-014 SHALL have port overrun_err  output  1  one-cycle pulse, completed frame dropped.
REQ-015 SHALL have port break_det  output  1  one-cycle pulse, break condition detected.

Function
REQ-016 SHALL pass rx through a 2-flop synchroniser (both flops 1 after reset); all decisions use the synchronised value rxs.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY visited only when PARITY != "NONE".
REQ-018 SHALL run baud counter 0..BIT_CYC-1 in all states except IDLE; cleared to 0 on IDLE->START.
REQ-019 SHALL move IDLE->START on rxs falling edge (previous 1, current 0).
REQ-020 SHALL decide each bit by 2-of-3 majority of rxs at counts MID-1, MID, MID+1; decision at count MID+1.
REQ-021 SHALL return START->IDLE without any output if start-bit majority is 1 (glitch reject); else proceed to DATA at end of bit.
REQ-022 SHALL shift DATA_BITS data decisions into rx_data order LSB first, then go to PARITY or STOP at end of last data bit.
REQ-023 SHALL compute parity: EVEN expects XOR(data)==parity bit; ODD expects XOR(data)!=parity bit; mismatch sets parity_err for that word; parity_err 0 when PARITY=="NONE".
REQ-024 SHALL sample STOP_BITS stop bits; frame_err = 1 if any stop decision is 0.
REQ-025 SHALL complete the frame at the decision point of the final stop bit and enter IDLE in the next cycle, so a start edge in the second half of the stop bit is caught.
REQ-026 SHALL on completion, if holding register empty or rx_rdy high that cycle, load rx_data, parity_err, frame_err and assert rx_vld the following cycle (latency 1 clk from final stop decision).
REQ-027 SHALL keep rx_vld, rx_data, flags stable until rx_vld && rx_rdy; then deassert rx_vld next cycle unless a new word loads the same cycle.
REQ-028 SHALL on completion while rx_vld=1 and rx_rdy=0: drop new frame, keep held word, pulse overrun_err 1 cycle.
REQ-029 SHALL pulse break_det 1 cycle when all data decisions, parity decision (if present) and first stop decision are 0; frame still delivered with frame_err=1.
REQ-030 SHALL deliver frames with errors (rx_vld asserted, flags set); consumer decides.

Reset
REQ-031 SHALL on rst_n=0 force IDLE, counters 0, rx_data 0, rx_vld 0, parity_err 0, frame_err 0, overrun_err 0, break_det 0, synchroniser 1.
REQ-032 SHALL abandon any in-progress frame on reset; no partial word delivered after release.

Verification (CLOCK=1_600_000, BAUD=100_000: BIT_CYC=16, MID=8)
REQ-033 SHALL test 8N1 byte 0xA5, rx_rdy=1 -> rx_vld 1 cycle after stop decision, rx_data=0xA5, flags 0.
REQ-034 SHALL test PARITY="EVEN", 0x07 with parity bit 0 -> rx_data=0x07, parity_err=1; with bit 1 -> parity_err=0.
REQ-035 SHALL test 4-cycle low glitch in idle -> returns IDLE, no rx_vld; 1-cycle spike inside a data bit at count MID -> majority rejects, byte correct.
REQ-036 SHALL test two back-to-back frames 0x11, 0x22, rx_rdy=0 -> rx_data stays 0x11, overrun_err pulses once; rx_rdy at completion cycle -> 0x22 loaded, no overrun.
REQ-037 SHALL test line held 0 for 12 bit times -> break_det pulse, frame_err=1, rx_data=0x00.
REQ-038 SHALL test rst_n low mid-DATA -> all outputs 0 immediately; next clean frame 0x3C received correctly.

Source files
------------

// File: rtl/uart_rx_ex.sv
// UART receiver: 2-flop synchroniser, 2-of-3 majority bit decisions, optional parity,
// 1 or 2 stop bits, one-word holding register with valid/ready, error and break reporting.
module uart_rx_ex #(
    parameter int    CLOCK     = 50_000_000,
    parameter int    BAUD      = 9600,
    parameter int    DATA_BITS = 8,
    parameter string PARITY    = "NONE",
    parameter int    STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_vld,
    input  logic                 rx_rdy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 break_det
);

    localparam int BIT_CYC    = CLOCK / BAUD;
    localparam int MID        = BIT_CYC / 2;
    localparam int CW         = $clog2(BIT_CYC + 1);
    localparam int BW         = $clog2(DATA_BITS);
    localparam bit HAS_PARITY = (PARITY != "NONE");
    localparam bit ODD_PARITY = (PARITY == "ODD");

    localparam logic [CW-1:0] CNT_S0    = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_S1    = CW'(MID);
    localparam logic [CW-1:0] CNT_DEC   = CW'(MID + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_CYC - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               state;
    state_t               next_state;
    logic                 rx_meta;
    logic                 rxs;
    logic                 rxs_prev;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic                 samp_a;
    logic                 samp_b;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_bit;
    logic                 first_stop;
    logic                 stop_bad;
    logic                 at_dec;
    logic                 at_end;
    logic                 bit_dec;
    logic                 frame_done;
    logic                 first_stop_dec;
    logic                 word_perr;
    logic                 word_ferr;
    logic                 word_break;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    // The third vote is the live synchronised value at the decision count.
    assign at_dec         = (cnt == CNT_DEC);
    assign at_end         = (cnt == CNT_LAST);
    assign bit_dec        = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
    assign frame_done     = (state == ST_STOP) && at_dec && (stop_cnt == LAST_STOP);
    assign first_stop_dec = (STOP_BITS == 1) ? bit_dec : first_stop;
    assign word_perr      = HAS_PARITY &&
                            (ODD_PARITY ? ((^shift_reg) == par_bit) : ((^shift_reg) != par_bit));
    assign word_ferr      = stop_bad | ~bit_dec;
    assign word_break     = (shift_reg == '0) && !(HAS_PARITY && par_bit) && !first_stop_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (rxs_prev && !rxs) next_state = ST_START;
            end
            ST_START: begin
                if (at_dec && bit_dec) next_state = ST_IDLE;
                else if (at_end)       next_state = ST_DATA;
            end
            ST_DATA: begin
                if (at_end && (bit_cnt == LAST_DATA)) begin
                    next_state = HAS_PARITY ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (at_end) next_state = ST_STOP;
            end
            ST_STOP: begin
                if (at_dec && (stop_cnt == LAST_STOP)) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            samp_a     <= 1'b1;
            samp_b     <= 1'b1;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            first_stop <= 1'b0;
            stop_bad   <= 1'b0;
        end else if (state == ST_IDLE) begin
            cnt      <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            stop_bad <= 1'b0;
        end else begin
            cnt <= at_end ? '0 : cnt + 1'b1;
            if (cnt == CNT_S0) samp_a <= rxs;
            if (cnt == CNT_S1) samp_b <= rxs;
            if (at_dec) begin
                if (state == ST_DATA)   shift_reg <= {bit_dec, shift_reg[DATA_BITS-1:1]};
                if (state == ST_PARITY) par_bit   <= bit_dec;
                if (state == ST_STOP) begin
                    if (!bit_dec)         stop_bad   <= 1'b1;
                    if (stop_cnt == 1'b0) first_stop <= bit_dec;
                end
            end
            if (at_end) begin
                if (state == ST_DATA) bit_cnt  <= bit_cnt + 1'b1;
                if (state == ST_STOP) stop_cnt <= stop_cnt + 1'b1;
            end
        end
    end

    // A finished frame is accepted when the holding register frees up in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data     <= '0;
            rx_vld      <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            break_det   <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            break_det   <= 1'b0;
            if (frame_done) begin
                break_det <= word_break;
                if (!rx_vld || rx_rdy) begin
                    rx_vld     <= 1'b1;
                    rx_data    <= shift_reg;
                    parity_err <= word_perr;
                    frame_err  <= word_ferr;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_vld && rx_rdy) begin
                rx_vld <= 1'b0;
            end
        end
    end

endmodule
